hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, EX-stage multiply latency in cycles (legal 1..8).
REQ-002 SHALL have ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- stall_axi_im_i  in  1  instruction-memory AXI stall.
- stall_axi_dm_i  in  1  data-memory AXI stall.
- id_rs1_i, id_rs2_i  in  5 each  source registers of the instruction in ID.
- id_uses_rs1_i, id_uses_rs2_i  in  1 each  ID instruction reads rs1 / rs2.
- ex_rd_i  in  5  destination register of the instruction in EX.
- ex_mem_read_i  in  1  EX instruction is a load.
- ex_mul_i  in  1  EX instruction is a multiply.
- ex_branch_taken_i  in  1  EX resolved a redirect (taken branch/jump).
- hold_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (EX instruction stays in EX).
- bubble_o  out  1  freeze PC and IF/ID; drives the ID/EX stall input (inserts a NOP into EX).
- id_flush_o  out  1  squash the instruction entering ID.
- ex_flush_o  out  1  squash the instruction entering EX.
- mul_done_o  out  1  the multiply in EX completes this cycle.
- stall_cnt_o  out  32  hazard-stall cycle count.
- flush_cnt_o  out  32  redirect-flush count.

Function
REQ-003 SHALL define axi_stall = stall_axi_im_i | stall_axi_dm_i; while axi_stall=1, state, counters and mul counter SHALL hold; the outputs SHALL still be driven combinationally from current inputs and state.
REQ-004 SHALL implement FSM states IDLE and MUL_WAIT with a 3-bit down-counter mul_cnt.
REQ-005 In IDLE with ex_mul_i=1 and MUL_LAT>1: hold_o=1; if axi_stall=0, next state MUL_WAIT, mul_cnt<=MUL_LAT-2.
REQ-006 In IDLE with ex_mul_i=1 and MUL_LAT=1: hold_o=0 and mul_done_o=1 in the same cycle; the FSM stays in IDLE.
REQ-007 In MUL_WAIT with mul_cnt!=0: hold_o=1; mul_cnt decrements on each cycle where axi_stall=0.
REQ-008 In MUL_WAIT with mul_cnt=0: hold_o=0, mul_done_o=1; if axi_stall=0, next state IDLE.
- A multiply therefore occupies EX for exactly MUL_LAT non-AXI-stalled cycles.
- A back-to-back multiply restarts from IDLE.
REQ-009 Load-use condition: ex_mem_read_i=1, ex_rd_i!=0, and ((id_uses_rs1_i and id_rs1_i==ex_rd_i) or (id_uses_rs2_i and id_rs2_i==ex_rd_i)).
REQ-010 bubble_o SHALL be 1 when the load-use condition holds, hold_o=0, and ex_branch_taken_i=0; otherwise 0.
REQ-011 id_flush_o and ex_flush_o SHALL both equal ex_branch_taken_i & ~hold_o, for one cycle per redirect.
REQ-012 Priority SHALL be: hold_o > redirect flush > bubble_o. Outputs are mutually exclusive except id_flush_o/ex_flush_o, which are always asserted together.
REQ-013 stall_cnt_o SHALL increment by 1 on each clock where (hold_o | bubble_o) & ~axi_stall.
REQ-014 flush_cnt_o SHALL increment by 1 on each clock where ex_flush_o & ~axi_stall.
REQ-015 Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-016 mul_done_o SHALL be 0 in every case not covered by REQ-006 and REQ-008.

Reset
REQ-017 On rst_i=1, asynchronously: state=IDLE, mul_cnt=0, stall_cnt_o=0, flush_cnt_o=0.
REQ-018 While rst_i=1, hold_o, bubble_o, id_flush_o, ex_flush_o and mul_done_o SHALL be forced to 0.
REQ-019 Reset asserted during MUL_WAIT SHALL abandon the multiply; the first cycle after reset starts in IDLE.

Structure
REQ-020 The shared defines package SHALL hold the FSM state enum (IDLE, MUL_WAIT) and the default multiply-latency constant.
REQ-021 Both 32-bit counters SHALL be instances of one sub-module, hz_event_cnt (enable, hold-on-stall, wrap), instantiated twice.

Verification
REQ-022 Scenario 1: MUL_LAT=3, ex_mul_i=1 at cycle 0, no AXI stall -> hold_o=1 at cycles 0-1; hold_o=0 and mul_done_o=1 at cycle 2; stall_cnt_o=2.
REQ-023 Scenario 2: ex_mem_read_i=1, ex_rd_i=5, id_rs2_i=5, id_uses_rs2_i=1 -> bubble_o=1 for one cycle; with ex_rd_i=0 -> bubble_o=0.
REQ-024 Scenario 3: ex_branch_taken_i=1 together with the load-use condition -> id_flush_o=ex_flush_o=1, bubble_o=0, flush_cnt_o increments by 1.
REQ-025 Scenario 4: MUL_LAT=3 multiply with stall_axi_dm_i=1 for 4 cycles after cycle 0 -> mul_cnt frozen and hold_o held throughout; mul_done_o occurs 4 cycles later than in Scenario 1; stall_cnt_o=2.
REQ-026 Scenario 5: rst_i pulsed in MUL_WAIT with mul_cnt=1 -> all outputs 0 immediately; after release with ex_mul_i=1, a fresh 3-cycle sequence runs.
REQ-027 Scenario 6: preload stall_cnt_o=0xFFFFFFFF, then one bubble cycle -> stall_cnt_o=0x00000000.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared FSM state type and default multiply latency
package hazard_ctrl_pkg;
   typedef enum logic {IDLE, MUL_WAIT} hz_state_e;
   localparam int MUL_LAT_DEF = 3;
endpackage

// File: rtl/hz_event_cnt.sv
// hz_event_cnt: 32-bit wrapping event counter that holds while the pipeline is AXI-stalled
module hz_event_cnt (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        stall_i,
   output logic [31:0] cnt_o
);
   logic [31:0] cnt_q, cnt_d;
   // next count wraps naturally at 32 bits
   always_comb cnt_d = cnt_q + 32'd1;
   // count only enabled, non-stalled cycles
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cnt_q <= '0;
      else if (en_i & ~stall_i) cnt_q <= cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: multiply-latency hold, load-use bubble and redirect flush control with event counters
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_axi_im_i,
   input  logic        stall_axi_dm_i,
   input  logic [4:0]  id_rs1_i,
   input  logic [4:0]  id_rs2_i,
   input  logic        id_uses_rs1_i,
   input  logic        id_uses_rs2_i,
   input  logic [4:0]  ex_rd_i,
   input  logic        ex_mem_read_i,
   input  logic        ex_mul_i,
   input  logic        ex_branch_taken_i,
   output logic        hold_o,
   output logic        bubble_o,
   output logic        id_flush_o,
   output logic        ex_flush_o,
   output logic        mul_done_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);
   localparam logic [2:0] MUL_INIT = 3'(MUL_LAT - 2);
   localparam bit MUL_MULTI = MUL_LAT > 1;
   hz_state_e  state_q, state_d;
   logic [2:0] mul_cnt_q, mul_cnt_d;
   logic       axi_stall, load_use, mul_hold, mul_fin;
   // hazard decode and next-state; outputs are forced quiet while in reset
   always_comb begin
      axi_stall = stall_axi_im_i | stall_axi_dm_i;
      load_use = ex_mem_read_i & (|ex_rd_i) &
                 ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) | (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));
      mul_hold = (state_q == MUL_WAIT) ? (mul_cnt_q != 3'd0) : (ex_mul_i & MUL_MULTI);
      mul_fin = (state_q == MUL_WAIT) ? (mul_cnt_q == 3'd0) : (ex_mul_i & ~MUL_MULTI);
      hold_o = ~rst_i & mul_hold;
      mul_done_o = ~rst_i & mul_fin;
      id_flush_o = ~rst_i & ex_branch_taken_i & ~mul_hold;
      ex_flush_o = id_flush_o;
      bubble_o = ~rst_i & load_use & ~mul_hold & ~ex_branch_taken_i;
      state_d = state_q;
      mul_cnt_d = mul_cnt_q;
      if (!axi_stall) begin
         if (state_q == IDLE && ex_mul_i && MUL_MULTI) begin
            state_d = MUL_WAIT;
            mul_cnt_d = MUL_INIT;
         end else if (state_q == MUL_WAIT) begin
            state_d = (mul_cnt_q == 3'd0) ? IDLE : MUL_WAIT;
            mul_cnt_d = (mul_cnt_q == 3'd0) ? 3'd0 : mul_cnt_q - 3'd1;
         end
      end
   end
   // multiply FSM state; reset abandons any multiply in flight
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state_q <= IDLE;
         mul_cnt_q <= 3'd0;
      end else begin
         state_q <= state_d;
         mul_cnt_q <= mul_cnt_d;
      end
   hz_event_cnt u_stall_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (hold_o | bubble_o),
      .stall_i(axi_stall),
      .cnt_o  (stall_cnt_o)
   );
   hz_event_cnt u_flush_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (ex_flush_o),
      .stall_i(axi_stall),
      .cnt_o  (flush_cnt_o)
   );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus multi-cycle sequences for hazard_ctrl
module tb_hazard_ctrl;
   logic        clk_i = 1'b0;
   logic        rst_i, im, dm, u1, u2, mr, mul, br;
   logic [4:0]  rs1, rs2, rd;
   logic        hold, bubble, idf, exf, done;
   logic [31:0] scnt, fcnt;
   logic        hold1, bubble1, idf1, exf1, done1;
   logic [31:0] scnt1, fcnt1;
   int          n_run = 0, n_fail = 0;
   always #5 clk_i = ~clk_i;

   hazard_ctrl #(.MUL_LAT(3)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_axi_im_i(im), .stall_axi_dm_i(dm),
      .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
      .ex_rd_i(rd), .ex_mem_read_i(mr), .ex_mul_i(mul), .ex_branch_taken_i(br),
      .hold_o(hold), .bubble_o(bubble), .id_flush_o(idf), .ex_flush_o(exf),
      .mul_done_o(done), .stall_cnt_o(scnt), .flush_cnt_o(fcnt));

   hazard_ctrl #(.MUL_LAT(1)) dut1 (
      .clk_i(clk_i), .rst_i(rst_i), .stall_axi_im_i(im), .stall_axi_dm_i(dm),
      .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs1_i(u1), .id_uses_rs2_i(u2),
      .ex_rd_i(rd), .ex_mem_read_i(mr), .ex_mul_i(mul), .ex_branch_taken_i(br),
      .hold_o(hold1), .bubble_o(bubble1), .id_flush_o(idf1), .ex_flush_o(exf1),
      .mul_done_o(done1), .stall_cnt_o(scnt1), .flush_cnt_o(fcnt1));

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, mr, br;
      logic       e_bub, e_fl;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic idle_inputs();
      im = 0; dm = 0; u1 = 0; u2 = 0; mr = 0; mul = 0; br = 0;
      rs1 = 0; rs2 = 0; rd = 0;
   endtask

   task automatic chk_outs(input string nm, input logic h, input logic b, input logic f, input logic d);
      chk({nm, ".hold"}, {31'd0, hold}, {31'd0, h});
      chk({nm, ".bubble"}, {31'd0, bubble}, {31'd0, b});
      chk({nm, ".flush"}, {30'd0, idf, exf}, {30'd0, f, f});
      chk({nm, ".done"}, {31'd0, done}, {31'd0, d});
   endtask

   initial begin
      vec_t        vt[9];
      logic [31:0] s0, f0;
      int          nb, nf;
      vt[0] = '{rs1:0,  rs2:5,  rd:5,  u1:0, u2:1, mr:1, br:0, e_bub:1, e_fl:0};
      vt[1] = '{rs1:0,  rs2:0,  rd:0,  u1:0, u2:1, mr:1, br:0, e_bub:0, e_fl:0};
      vt[2] = '{rs1:5,  rs2:0,  rd:5,  u1:1, u2:0, mr:1, br:0, e_bub:1, e_fl:0};
      vt[3] = '{rs1:5,  rs2:0,  rd:5,  u1:0, u2:0, mr:1, br:0, e_bub:0, e_fl:0};
      vt[4] = '{rs1:7,  rs2:3,  rd:3,  u1:1, u2:1, mr:0, br:0, e_bub:0, e_fl:0};
      vt[5] = '{rs1:7,  rs2:3,  rd:4,  u1:1, u2:1, mr:1, br:0, e_bub:0, e_fl:0};
      vt[6] = '{rs1:0,  rs2:5,  rd:5,  u1:0, u2:1, mr:1, br:1, e_bub:0, e_fl:1};
      vt[7] = '{rs1:1,  rs2:2,  rd:9,  u1:1, u2:1, mr:0, br:1, e_bub:0, e_fl:1};
      vt[8] = '{rs1:31, rs2:31, rd:31, u1:1, u2:1, mr:1, br:0, e_bub:1, e_fl:0};

      idle_inputs();
      rst_i = 1;
      #1;
      chk_outs("reset", 0, 0, 0, 0);
      chk("reset.stall_cnt", scnt, 0);
      chk("reset.flush_cnt", fcnt, 0);
      @(negedge clk_i);
      rst_i = 0;

      // combinational hazard table, FSM idle throughout
      nb = 0; nf = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk_i);
         rs1 = vt[i].rs1; rs2 = vt[i].rs2; rd = vt[i].rd;
         u1 = vt[i].u1; u2 = vt[i].u2; mr = vt[i].mr; br = vt[i].br;
         nb += int'(vt[i].e_bub);
         nf += int'(vt[i].e_fl);
         #1;
         chk($sformatf("vec%0d", i), {29'd0, bubble, idf, exf},
             {29'd0, vt[i].e_bub, vt[i].e_fl, vt[i].e_fl});
         chk($sformatf("vec%0d.hold", i), {31'd0, hold}, 0);
      end
      @(negedge clk_i);
      idle_inputs();
      #1;
      chk("table.stall_cnt", scnt, nb);
      chk("table.flush_cnt", fcnt, nf);

      // redirect under AXI stall: flush still driven, count holds
      f0 = fcnt;
      @(negedge clk_i);
      br = 1; dm = 1;
      #1;
      chk("axi_br.flush", {31'd0, exf}, 1);
      @(negedge clk_i);
      idle_inputs();
      #1;
      chk("axi_br.flush_cnt", fcnt, f0);

      // scenario 1: 3-cycle multiply; hold outranks redirect and load-use
      s0 = scnt; f0 = fcnt;
      @(negedge clk_i);
      mul = 1; br = 1; mr = 1; rd = 5; rs2 = 5; u2 = 1;
      #1;
      chk_outs("mul.c0", 1, 0, 0, 0);
      chk("mul1.c0", {30'd0, hold1, done1}, {30'd0, 1'b0, 1'b1});
      @(negedge clk_i);
      br = 0; mr = 0; rd = 0; rs2 = 0; u2 = 0;
      #1;
      chk_outs("mul.c1", 1, 0, 0, 0);
      chk("mul1.c1", {30'd0, hold1, done1}, {30'd0, 1'b0, 1'b1});
      @(negedge clk_i);
      #1;
      chk_outs("mul.c2", 0, 0, 0, 1);
      @(negedge clk_i);
      mul = 0;
      #1;
      chk_outs("mul.c3", 0, 0, 0, 0);
      chk("mul.stall_cnt", scnt - s0, 2);
      chk("mul.flush_cnt", fcnt - f0, 0);

      // scenario 4: AXI stall for 4 cycles after cycle 0 delays done by 4
      s0 = scnt;
      @(negedge clk_i);
      mul = 1;
      #1;
      chk_outs("mulaxi.c0", 1, 0, 0, 0);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk_i);
         dm = (c <= 4);
         #1;
         chk_outs($sformatf("mulaxi.c%0d", c), c < 6, 0, 0, c == 6);
      end
      @(negedge clk_i);
      idle_inputs();
      #1;
      chk("mulaxi.stall_cnt", scnt - s0, 2);

      // scenario 5: reset in MUL_WAIT with mul_cnt=1, then a fresh multiply
      @(negedge clk_i);
      mul = 1;
      @(negedge clk_i);
      #1;
      chk("rstmul.pre_hold", {31'd0, hold}, 1);
      rst_i = 1; br = 1; mr = 1; rd = 5; rs2 = 5; u2 = 1;
      #1;
      chk_outs("rstmul.in_reset", 0, 0, 0, 0);
      chk("rstmul.stall_cnt", scnt, 0);
      chk("rstmul.flush_cnt", fcnt, 0);
      @(negedge clk_i);
      rst_i = 0; br = 0; mr = 0; rd = 0; rs2 = 0; u2 = 0;
      #1;
      chk_outs("rstmul.c0", 1, 0, 0, 0);
      @(negedge clk_i);
      #1;
      chk_outs("rstmul.c1", 1, 0, 0, 0);
      @(negedge clk_i);
      #1;
      chk_outs("rstmul.c2", 0, 0, 0, 1);
      @(negedge clk_i);
      mul = 0;
      #1;
      chk("rstmul.stall_cnt_after", scnt, 2);

      // scenario 6: stall counter wraps from all-ones
      @(negedge clk_i);
      force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.u_stall_cnt.cnt_q;
      #1;
      chk("wrap.preload", scnt, 32'hFFFF_FFFF);
      @(negedge clk_i);
      mr = 1; rd = 7; rs1 = 7; u1 = 1;
      #1;
      chk("wrap.bubble", {31'd0, bubble}, 1);
      @(negedge clk_i);
      idle_inputs();
      #1;
      chk("wrap.stall_cnt", scnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
